// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types for the pipeline hazard unit.
//   fwd_sel_t  - E-stage operand forwarding select encoding
//   md_state_t - mul/div occupancy sequencer states
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        MD_IDLE,
        MD_BUSY
    } md_state_t;

    localparam int MD_CNT_W = 3;

endpackage

// File: rtl/md_stall_fsm.sv
// md_stall_fsm: holds a multi-cycle mul/div op in E for MD_LATENCY-1 stall cycles.
//   clk      in  clock, rising edge
//   reset    in  asynchronous, active-low reset
//   mdstartE in  mul/div op present in E
//   mdstall  out stall request; forced low while reset is asserted
module md_stall_fsm
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic mdstartE,
    output logic mdstall
);

    md_state_t             state, state_nx;
    logic [MD_CNT_W-1:0]   mdcnt, mdcnt_nx;
    logic                  stall_raw;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MD_IDLE;
            mdcnt <= '0;
        end else begin
            state <= state_nx;
            mdcnt <= mdcnt_nx;
        end
    end

    // The cycle mdstartE is first seen already stalls, so the counter only
    // needs to cover the remaining MD_LATENCY-2 stall cycles.
    always_comb begin
        state_nx  = state;
        mdcnt_nx  = mdcnt;
        stall_raw = 1'b0;
        case (state)
            MD_IDLE: begin
                if (mdstartE) begin
                    state_nx  = MD_BUSY;
                    mdcnt_nx  = MD_CNT_W'(MD_LATENCY - 2);
                    stall_raw = 1'b1;
                end
            end
            MD_BUSY: begin
                if (mdcnt != '0) begin
                    mdcnt_nx  = mdcnt - 1'b1;
                    stall_raw = 1'b1;
                end else begin
                    state_nx = MD_IDLE;
                end
            end
            default: state_nx = MD_IDLE;
        endcase
    end

    // Gating with reset makes mdbusy drop at once, even if mdstartE is still high.
    assign mdstall = stall_raw & reset;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: forwarding selects, stall/flush control and event counters
// for the 5-stage MIPS pipeline.
//   clk, reset                      clock; asynchronous active-low reset
//   rsD, rtD, rsE, rtE              source register specifiers in D and E
//   writeregE/M/W                   destination registers in E, M, W
//   branchD, bneD                   branch in D
//   memtoregE/M, regwriteE/M/W      load / register-write flags per stage
//   mdstartE                        mul/div op in E
//   forwardaD, forwardbD            D comparator operands take aluoutM
//   forwardaE, forwardbE            E operand selects (00 rf, 01 resultW, 10 aluoutM)
//   stallF, stallD, stallE          pipeline register holds
//   flushE, flushM                  bubble insertion
//   mdbusy                          mul/div stall active
//   stall_cnt, flush_cnt            saturating counts of stallD / flushE cycles
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rsE,
    input  logic [4:0]       rtE,
    input  logic [4:0]       writeregE,
    input  logic [4:0]       writeregM,
    input  logic [4:0]       writeregW,
    input  logic             branchD,
    input  logic             bneD,
    input  logic             memtoregE,
    input  logic             memtoregM,
    input  logic             regwriteE,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             mdstartE,
    output logic             forwardaD,
    output logic             forwardbD,
    output logic [1:0]       forwardaE,
    output logic [1:0]       forwardbE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             flushE,
    output logic             flushM,
    output logic             mdbusy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic lwstall, brstall, mdstall, dep_e, dep_m;

    assign forwardaE = (rsE != '0 && rsE == writeregM && regwriteM) ? FWD_MEM :
                       (rsE != '0 && rsE == writeregW && regwriteW) ? FWD_WB  : FWD_RF;
    assign forwardbE = (rtE != '0 && rtE == writeregM && regwriteM) ? FWD_MEM :
                       (rtE != '0 && rtE == writeregW && regwriteW) ? FWD_WB  : FWD_RF;
    assign forwardaD = rsD != '0 && rsD == writeregM && regwriteM;
    assign forwardbD = rtD != '0 && rtD == writeregM && regwriteM;

    // Branches resolve in D, so a result still in E, or a load still in M,
    // cannot reach the comparator in time.
    assign dep_e   = regwriteE && (writeregE == rsD || writeregE == rtD);
    assign dep_m   = memtoregM && (writeregM == rsD || writeregM == rtD);
    assign lwstall = memtoregE && (rtE == rsD || rtE == rtD);
    assign brstall = (branchD | bneD) && (dep_e || dep_m);

    md_stall_fsm #(.MD_LATENCY(MD_LATENCY)) u_md (
        .clk      (clk),
        .reset    (reset),
        .mdstartE (mdstartE),
        .mdstall  (mdstall)
    );

    assign stallF = lwstall | brstall | mdstall;
    assign stallD = stallF;
    assign stallE = mdstall;
    assign flushM = mdstall;
    assign mdbusy = mdstall;
    // E holds the mul/div op, so it must not be bubbled at the same time.
    assign flushE = (lwstall | brstall) & ~mdstall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stallD && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flushE && !(&flush_cnt)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed checks of forwarding, stalls, mul/div sequencing,
// reset behaviour and counter saturation.
module tb_hazard_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic        branchD, bneD, memtoregE, memtoregM, regwriteE, regwriteM, regwriteW, mdstartE;
    logic        forwardaD, forwardbD, stallF, stallD, stallE, flushE, flushM, mdbusy;
    logic [1:0]  forwardaE, forwardbE;
    logic [15:0] stall_cnt, flush_cnt;
    logic        n_forwardaD, n_forwardbD, n_stallF, n_stallD, n_stallE, n_flushE, n_flushM, n_mdbusy;
    logic [1:0]  n_forwardaE, n_forwardbE;
    logic [3:0]  stall_cnt4, flush_cnt4;
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    hazard_unit dut (
        .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .branchD(branchD), .bneD(bneD), .memtoregE(memtoregE), .memtoregM(memtoregM),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW), .mdstartE(mdstartE),
        .forwardaD(forwardaD), .forwardbD(forwardbD), .forwardaE(forwardaE), .forwardbE(forwardbE),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .flushE(flushE), .flushM(flushM),
        .mdbusy(mdbusy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
        .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
        .branchD(branchD), .bneD(bneD), .memtoregE(memtoregE), .memtoregM(memtoregM),
        .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW), .mdstartE(mdstartE),
        .forwardaD(n_forwardaD), .forwardbD(n_forwardbD), .forwardaE(n_forwardaE), .forwardbE(n_forwardbE),
        .stallF(n_stallF), .stallD(n_stallD), .stallE(n_stallE), .flushE(n_flushE), .flushM(n_flushM),
        .mdbusy(n_mdbusy), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        {rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW} = '0;
        {branchD, bneD, memtoregE, memtoregM, regwriteE, regwriteM, regwriteW, mdstartE} = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lw_use();
        memtoregE = 1'b1; rtE = 5'd9; rsD = 5'd9;
    endtask

    initial begin
        clr();
        reset = 1'b0;
        #2;
        check("rst_stall_cnt", 32'(stall_cnt), 0);
        check("rst_flush_cnt", 32'(flush_cnt), 0);
        check("rst_mdbusy", 32'(mdbusy), 0);
        tick();
        reset = 1'b1;

        // forwarding
        regwriteM = 1; writeregM = 8; regwriteW = 1; writeregW = 8; rsE = 8;
        #1 check("fwdaE_mem_over_wb", 32'(forwardaE), 2);
        check("fwdbE_rt0", 32'(forwardbE), 0);
        writeregM = 0; writeregW = 0; rsE = 0;
        #1 check("fwdaE_r0", 32'(forwardaE), 0);
        regwriteM = 0; writeregW = 8; rsE = 8;
        #1 check("fwdaE_wb", 32'(forwardaE), 1);
        regwriteM = 1; writeregM = 7; rtE = 7;
        #1 check("fwdbE_mem", 32'(forwardbE), 2);
        check("fwdaE_wb2", 32'(forwardaE), 1);
        clr();
        tick();

        // load-use
        lw_use();
        #1 check("lw_stallF", 32'(stallF), 1);
        check("lw_stallD", 32'(stallD), 1);
        check("lw_flushE", 32'(flushE), 1);
        check("lw_stallE", 32'(stallE), 0);
        check("lw_flushM", 32'(flushM), 0);
        tick(); tick(); tick();
        check("lw_stall_cnt", 32'(stall_cnt), 3);
        check("lw_flush_cnt", 32'(flush_cnt), 3);
        clr();

        // branch hazards
        branchD = 1; regwriteE = 1; writeregE = 4; rsD = 4;
        #1 check("br_e_stallD", 32'(stallD), 1);
        check("br_e_flushE", 32'(flushE), 1);
        tick();
        regwriteE = 0; writeregE = 0; memtoregM = 1; writeregM = 4;
        #1 check("br_m_stallD", 32'(stallD), 1);
        check("br_m_fwdaD", 32'(forwardaD), 0);
        tick();
        memtoregM = 0; regwriteM = 1;
        #1 check("br_fwd_fwdaD", 32'(forwardaD), 1);
        check("br_fwd_stallD", 32'(stallD), 0);
        check("br_fwd_flushE", 32'(flushE), 0);
        tick();
        check("br_stall_cnt", 32'(stall_cnt), 5);
        check("br_flush_cnt", 32'(flush_cnt), 5);
        clr();

        // mul/div: pattern with mdstartE held across two ops
        mdstartE = 1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("md_busy_%0d", i), 32'(mdbusy), (i % 4 == 3) ? 0 : 1);
            check($sformatf("md_stallE_%0d", i), 32'(stallE), (i % 4 == 3) ? 0 : 1);
            check($sformatf("md_flushM_%0d", i), 32'(flushM), (i % 4 == 3) ? 0 : 1);
            check($sformatf("md_stallF_%0d", i), 32'(stallF), (i % 4 == 3) ? 0 : 1);
            if (i < 7) tick();
        end
        mdstartE = 0;
        tick();
        check("md_stall_cnt", 32'(stall_cnt), 11);
        check("md_flush_cnt", 32'(flush_cnt), 5);

        // mul/div together with load-use
        mdstartE = 1; lw_use();
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("mdlw_stallD_%0d", i), 32'(stallD), 1);
            check($sformatf("mdlw_flushE_%0d", i), 32'(flushE), 0);
            tick();
        end
        mdstartE = 0;
        #1 check("mdlw_after_busy", 32'(mdbusy), 0);
        check("mdlw_after_flushE", 32'(flushE), 1);
        check("mdlw_after_stallD", 32'(stallD), 1);
        tick();
        check("mdlw_stall_cnt", 32'(stall_cnt), 15);
        check("mdlw_flush_cnt", 32'(flush_cnt), 6);
        clr();

        // reset in the middle of a mul/div op
        mdstartE = 1;
        tick();
        check("mid_busy", 32'(mdbusy), 1);
        check("mid_stall_cnt", 32'(stall_cnt), 16);
        check("mid_stall_cnt4_sat", 32'(stall_cnt4), 15);
        reset = 0;
        #1 check("rstmid_busy", 32'(mdbusy), 0);
        check("rstmid_stallE", 32'(stallE), 0);
        check("rstmid_stall_cnt", 32'(stall_cnt), 0);
        check("rstmid_flush_cnt", 32'(flush_cnt), 0);
        check("rstmid_stall_cnt4", 32'(stall_cnt4), 0);
        mdstartE = 0;
        tick(); tick();
        reset = 1;
        #1 check("rel_busy", 32'(mdbusy), 0);
        tick();
        check("rel_busy2", 32'(mdbusy), 0);
        check("rel_stall_cnt", 32'(stall_cnt), 0);

        // saturation of the narrow counter
        lw_use();
        for (int i = 0; i < 14; i++) tick();
        check("sat_cnt4_14", 32'(stall_cnt4), 14);
        tick();
        check("sat_cnt4_15", 32'(stall_cnt4), 15);
        for (int i = 0; i < 5; i++) tick();
        check("sat_cnt4_20", 32'(stall_cnt4), 15);
        check("sat_flush4_20", 32'(flush_cnt4), 15);
        check("sat_cnt16_20", 32'(stall_cnt), 20);
        check("sat_flush16_20", 32'(flush_cnt), 20);
        clr();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
